regfile_wb_ctrl: RTL

Write-back and reservation controller for an array of `register_cell` instances. It arbitrates round-robin among `NUM_REQ` functional-unit write-back requesters for the register file's single write port. It drives the per-cell write-back strobes and broadcast data, and accepts destination-register reservations from the issue stage. It sits between the issue/execute stages and the register cell array, and checks that every write-back targets a reserved register.

---
 rtl/regfile_wb_ctrl_pkg.sv | 21 ++
 rtl/regfile_wb_ctrl_if.sv | 27 ++
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 37 +++
 rtl/regfile_wb_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back/reservation controller.
// Holds the default geometry and the one-hot decoder used for cell strobes.
package venus_regfile_pkg;

  localparam int REG_LEN  = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_LEN = 5;

  // The decoder works on a fixed wide vector; callers slice it down to NUM_REGS.
  localparam int MAX_REGS = 64;

  function automatic logic [MAX_REGS-1:0] onehot_decode(input int unsigned addr, input logic en);
    logic [MAX_REGS-1:0] vec;
    vec = '0;
    if (en && addr < MAX_REGS) begin
      vec = {{(MAX_REGS-1){1'b0}}, 1'b1} << addr;
    end
    return vec;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Requester and issue-stage handshake bundle for regfile_wb_ctrl.
// Master is the execute/issue side, slave is the controller.
interface regfile_wb_ctrl_if #(
  parameter int REG_LEN  = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_REQ  = 4
);

  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ*ADDR_LEN-1:0] req_addr_i;
  logic [NUM_REQ*REG_LEN-1:0]  req_data_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic                        rsv_valid_i;
  logic [ADDR_LEN-1:0]         rsv_addr_i;
  logic                        rsv_ready_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
    input  req_ready_o, rsv_ready_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
    output req_ready_o, rsv_ready_o
  );

endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic found;

  // Two passes: upper segment [ptr..N-1] first, then the wrapped segment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter and reservation controller in front of a register_cell array.
// One write-back per cycle through a single drain-always stage; reservations are combinational.
module regfile_wb_ctrl #(
  parameter int REG_LEN  = venus_regfile_pkg::REG_LEN,
  parameter int NUM_REGS = venus_regfile_pkg::NUM_REGS,
  parameter int ADDR_LEN = venus_regfile_pkg::ADDR_LEN,
  parameter int NUM_REQ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_ctrl_if.slave    bus,
  input  logic [NUM_REGS-1:0] cell_reserve_i,
  output logic [NUM_REGS-1:0] cell_reserve_o,
  output logic [NUM_REGS-1:0] cell_wb_o,
  output logic [REG_LEN-1:0]  cell_data_o,
  output logic                err_o
);

  import venus_regfile_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                any_grant;
  logic [ADDR_LEN-1:0] gnt_addr;
  logic [REG_LEN-1:0]  gnt_data;
  logic                gnt_ok;
  logic                rsv_free;
  logic                wb_valid;
  logic [ADDR_LEN-1:0] wb_addr;
  logic [REG_LEN-1:0]  wb_data;

  // Out-of-range addresses decode to nothing, so they never hit a cell.
  function automatic logic [NUM_REGS-1:0] dec(input logic [ADDR_LEN-1:0] a, input logic en);
    logic [MAX_REGS-1:0] wide;
    wide = onehot_decode(32'(a), en && (int'(a) < NUM_REGS));
    return wide[NUM_REGS-1:0];
  endfunction

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        gnt_addr = bus.req_addr_i[k*ADDR_LEN +: ADDR_LEN];
        gnt_data = bus.req_data_i[k*REG_LEN +: REG_LEN];
      end
    end
  end

  assign any_grant       = |grant;
  assign gnt_ok          = |(cell_reserve_i & dec(gnt_addr, 1'b1));
  assign bus.req_ready_o = grant;

  // A still-reserved register stalls the new reservation (write-after-write).
  assign rsv_free        = (int'(bus.rsv_addr_i) < NUM_REGS) &&
                           !(|(cell_reserve_i & dec(bus.rsv_addr_i, 1'b1)));
  assign bus.rsv_ready_o = bus.rsv_valid_i && rsv_free;
  assign cell_reserve_o  = dec(bus.rsv_addr_i, bus.rsv_ready_o);

  assign cell_wb_o   = dec(wb_addr, wb_valid);
  assign cell_data_o = wb_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      err_o    <= 1'b0;
    end else if (any_grant) begin
      rr_ptr   <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
      wb_valid <= 1'b1;
      wb_addr  <= gnt_addr;
      wb_data  <= gnt_data;
      if (!gnt_ok) begin
        err_o <= 1'b1;
      end
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule
